// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: stall/flush/redirect control, BTB update strobe and the
// registered fetch PC with its branch prediction.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            i_stall;
  logic            i_flush_valid;
  logic [XLEN-1:0] i_flush_pc;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_upd_valid;
  logic [XLEN-1:0] i_upd_pc;
  logic [XLEN-1:0] i_upd_target;
  logic            i_upd_taken;
  logic [XLEN-1:0] o_pc;
  logic            o_pred_taken;
  logic [XLEN-1:0] o_pred_target;

  modport master (
    output i_stall, i_flush_valid, i_flush_pc, i_redirect_valid, i_redirect_pc,
           i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken,
    input  o_pc, o_pred_taken, o_pred_target
  );

  modport slave (
    input  i_stall, i_flush_valid, i_flush_pc, i_redirect_valid, i_redirect_pc,
           i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken,
    output o_pc, o_pred_taken, o_pred_target
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with a direct-mapped BTB (2-bit saturating counters)
// providing next-PC prediction; flush and redirect take priority over stall.
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_DEPTH    = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  pc_fetch_unit_if.slave bus
);
  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};

  logic [XLEN-1:0]      r_pc;
  logic [BTB_DEPTH-1:0] r_valid;
  logic [1:0]           r_ctr    [BTB_DEPTH];
  logic [TAGW-1:0]      r_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      r_target [BTB_DEPTH];

  logic [IDXW-1:0] w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic            w_lk_hit;
  logic            w_pred_taken;
  logic [IDXW-1:0] w_up_idx;
  logic [TAGW-1:0] w_up_tag;
  logic            w_up_hit;
  logic [XLEN-1:0] w_next_pc;

  assign w_lk_idx     = r_pc[IDXW+1:2];
  assign w_lk_tag     = r_pc[XLEN-1:IDXW+2];
  assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken = w_lk_hit && r_ctr[w_lk_idx][1];

  assign w_up_idx = bus.i_upd_pc[IDXW+1:2];
  assign w_up_tag = bus.i_upd_pc[XLEN-1:IDXW+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  assign bus.o_pc          = r_pc;
  assign bus.o_pred_taken  = w_pred_taken;
  assign bus.o_pred_target = w_lk_hit ? r_target[w_lk_idx] : '0;

  // NOTE: the sequential default is assigned first so every path drives w_next_pc and no latch is inferred.
  always_comb begin
    w_next_pc = r_pc + PC_STEP;
    if (bus.i_flush_valid)         w_next_pc = bus.i_flush_pc & ALIGN_MASK;
    else if (bus.i_redirect_valid) w_next_pc = bus.i_redirect_pc & ALIGN_MASK;
    else if (bus.i_stall)          w_next_pc = r_pc;
    else if (w_pred_taken)         w_next_pc = r_target[w_lk_idx] & ALIGN_MASK;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_pc <= RESET_VECTOR;
    else         r_pc <= w_next_pc;
  end

  // Direction state: valid bits and counters are the only BTB state that needs reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) r_ctr[i] <= 2'b01;
    end else if (bus.i_upd_valid) begin
      if (w_up_hit) begin
        if (bus.i_upd_taken)
          r_ctr[w_up_idx] <= (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
        else
          r_ctr[w_up_idx] <= (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;
      end else if (bus.i_upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= 2'b10;
      end
    end
  end

  // NOTE: tag/target arrays are not reset; a cleared valid bit hides whatever they hold.
  always_ff @(posedge i_clk) begin
    if (bus.i_upd_valid && bus.i_upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= bus.i_upd_target;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_pc_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam int          IDXW  = $clog2(DEPTH);
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  pc_fetch_unit_if #(.XLEN(XLEN)) bus ();

  pc_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .BTB_DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit [31:0] m_pc;
  bit        m_valid [DEPTH];
  bit [31:0] m_tag   [DEPTH];
  bit [31:0] m_tgt   [DEPTH];
  int        m_ctr   [DEPTH];

  function automatic int m_idx(bit [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit [31:0] m_tagof(bit [31:0] pc);
    return pc >> (IDXW + 2);
  endfunction

  function automatic bit m_hit(bit [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(bit [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic bit [31:0] m_target(bit [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RV;
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
    end else begin
      bit [31:0] nxt;
      int        ui;
      if (bus.i_flush_valid)         nxt = bus.i_flush_pc & ~32'h3;
      else if (bus.i_redirect_valid) nxt = bus.i_redirect_pc & ~32'h3;
      else if (bus.i_stall)          nxt = m_pc;
      else if (m_taken(m_pc))        nxt = m_target(m_pc) & ~32'h3;
      else                           nxt = m_pc + 32'd4;
      if (bus.i_upd_valid) begin
        ui = m_idx(bus.i_upd_pc);
        if (m_hit(bus.i_upd_pc)) begin
          if (bus.i_upd_taken) begin
            if (m_ctr[ui] < 3) m_ctr[ui]++;
            m_tgt[ui] = bus.i_upd_target;
          end else if (m_ctr[ui] > 0) begin
            m_ctr[ui]--;
          end
        end else if (bus.i_upd_taken) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = m_tagof(bus.i_upd_pc);
          m_tgt[ui]   = bus.i_upd_target;
          m_ctr[ui]   = 2;
        end
      end
      m_pc = nxt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_pc", bus.o_pc, m_pc);
      check("model_pred_taken", {31'b0, bus.o_pred_taken}, {31'b0, m_taken(m_pc)});
      check("model_pred_target", bus.o_pred_target, m_target(m_pc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.i_stall          = 1'b0;
    bus.i_flush_valid    = 1'b0;
    bus.i_flush_pc       = '0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_upd_valid      = 1'b0;
    bus.i_upd_pc         = '0;
    bus.i_upd_target     = '0;
    bus.i_upd_taken      = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = pc;
    cyc();
    bus.i_redirect_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    bus.i_upd_valid  = 1'b1;
    bus.i_upd_pc     = pc;
    bus.i_upd_target = tgt;
    bus.i_upd_taken  = tk;
  endtask

  initial begin
    idle();
    cyc();
    cmp_en = 1'b1;
    check("reset_pc", bus.o_pc, 32'h0);
    check("reset_pred", {31'b0, bus.o_pred_taken}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Sequential fetch from the reset vector
    check("seq_0", bus.o_pc, 32'h0);
    cyc(); check("seq_4", bus.o_pc, 32'h4);
    cyc(); check("seq_8", bus.o_pc, 32'h8);
    cyc(); check("seq_c", bus.o_pc, 32'hC);
    cyc(); check("seq_10", bus.o_pc, 32'h10);

    // Stall holds, redirect overrides stall
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); check("stall_hold", bus.o_pc, 32'h10);
    end
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h200;
    cyc(); check("redirect_in_stall", bus.o_pc, 32'h200);
    idle();

    // Flush beats redirect
    bus.i_flush_valid    = 1'b1;
    bus.i_flush_pc       = 32'h80;
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h200;
    cyc(); check("flush_priority", bus.o_pc, 32'h80);
    idle();

    // Allocate and predict
    upd(32'h40, 32'h100, 1'b1);
    cyc(); idle();
    redirect_to(32'h3B);
    check("redirect_aligned", bus.o_pc, 32'h38);
    cyc(); cyc();
    check("btb_pc40", bus.o_pc, 32'h40);
    check("btb_pred_taken", {31'b0, bus.o_pred_taken}, 32'h1);
    check("btb_pred_target", bus.o_pred_target, 32'h100);
    cyc(); check("btb_follow", bus.o_pc, 32'h100);

    // Two not-taken updates drive the counter to 0
    upd(32'h40, 32'h0, 1'b0);
    cyc(); cyc(); idle();
    redirect_to(32'h40);
    check("btb_nt_pred", {31'b0, bus.o_pred_taken}, 32'h0);
    check("btb_nt_hit_target", bus.o_pred_target, 32'h100);

    // Retrain, then alias 0x80 onto the same index
    upd(32'h40, 32'h100, 1'b1);
    cyc(); cyc(); idle();
    redirect_to(32'h40);
    check("retrain_pred", {31'b0, bus.o_pred_taken}, 32'h1);
    upd(32'h80, 32'h300, 1'b1);
    cyc(); idle();
    check("no_bypass", bus.o_pc, 32'h100);
    redirect_to(32'h40);
    check("alias_miss_pred", {31'b0, bus.o_pred_taken}, 32'h0);
    check("alias_miss_target", bus.o_pred_target, 32'h0);
    redirect_to(32'h80);
    check("alias_new_pred", {31'b0, bus.o_pred_taken}, 32'h1);
    check("alias_new_target", bus.o_pred_target, 32'h300);

    // Wrap-around
    redirect_to(32'hFFFF_FFFC);
    check("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
    cyc(); check("wrap_next", bus.o_pc, 32'h0);

    // Async reset mid-cycle discards same-cycle update and flush
    upd(32'h40, 32'h500, 1'b1);
    bus.i_flush_valid = 1'b1;
    bus.i_flush_pc    = 32'h600;
    #1 rst = 1'b1;
    #1 check("async_reset_pc", bus.o_pc, RV);
    check("async_reset_pred", {31'b0, bus.o_pred_taken}, 32'h0);
    cyc(); check("reset_hold_pc", bus.o_pc, RV);
    idle();
    rst = 1'b0;
    cyc(); check("post_reset_step", bus.o_pc, 32'h4);
    redirect_to(32'h80);
    check("btb_cleared_80", {31'b0, bus.o_pred_taken}, 32'h0);
    redirect_to(32'h40);
    check("btb_cleared_40", {31'b0, bus.o_pred_taken}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.i_stall          = ($urandom_range(0, 9) < 3);
      bus.i_flush_valid    = ($urandom_range(0, 19) == 0);
      bus.i_flush_pc       = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      bus.i_redirect_valid = ($urandom_range(0, 19) < 2);
      bus.i_redirect_pc    = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      bus.i_upd_valid      = ($urandom_range(0, 9) < 4);
      bus.i_upd_pc         = ($urandom_range(0, 1) == 0) ? m_pc : ($urandom_range(0, 63) << 2);
      bus.i_upd_target     = $urandom_range(0, 63) << 2;
      bus.i_upd_taken      = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      cyc();
    end
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning PC/target width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 The block SHALL have parameter BTB_DEPTH, default 16, meaning direct-mapped BTB entries; it must be a power of two and at least 2.
REQ-004 The block SHALL have port i_clk  input  1  system clock, all state rising-edge.
REQ-005 The block SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port i_stall  input  1  high = hold PC (fetch stall).
REQ-007 The block SHALL have port i_flush_valid  input  1  trap/exception redirect request.
REQ-008 The block SHALL have port i_flush_pc  input  XLEN  trap/exception target.
REQ-009 The block SHALL have port i_redirect_valid  input  1  resolved-branch mispredict redirect.
REQ-010 The block SHALL have port i_redirect_pc  input  XLEN  correct branch/jump target.
REQ-011 The block SHALL have port i_upd_valid  input  1  BTB update strobe from execute.
REQ-012 The block SHALL have port i_upd_pc  input  XLEN  PC of the resolved control-transfer instruction.
REQ-013 The block SHALL have port i_upd_target  input  XLEN  resolved target.
REQ-014 The block SHALL have port i_upd_taken  input  1  resolved direction, 1 = taken.
REQ-015 The block SHALL have port o_pc  output  XLEN  current fetch PC (registered).
REQ-016 The block SHALL have port o_pred_taken  output  1  BTB predicts o_pc is a taken branch.
REQ-017 The block SHALL have port o_pred_target  output  XLEN  predicted target, valid when o_pred_taken = 1.

Function
REQ-018 The next PC SHALL be chosen by priority: flush > redirect > stall (hold) > predicted taken (o_pred_target) > o_pc + 4.
REQ-019 Flush and redirect SHALL override i_stall.
REQ-020 o_pc + 4 SHALL be computed modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0x0000_0000 at XLEN = 32.
REQ-021 Bits [1:0] of every loaded flush, redirect or predicted target SHALL be forced to 0.
REQ-022 Each BTB entry SHALL hold: valid bit, tag = PC[XLEN-1 : IDXW+2], target (XLEN), and a 2-bit saturating counter; IDXW = log2(BTB_DEPTH) and index = PC[IDXW+1:2].
REQ-023 Lookup SHALL be combinational on o_pc: hit = valid AND tag match; o_pred_taken = hit AND counter[1]; o_pred_target = entry target when hit, otherwise 0.
REQ-024 An update with a hit SHALL increment the counter (saturating at 3) when taken, decrement it (saturating at 0) when not taken, and write the target only when taken.
REQ-025 An update with a miss and taken = 1 SHALL allocate the entry (overwriting any existing entry): valid = 1, new tag, target, counter = 2'b10.
REQ-026 An update with a miss and taken = 0 SHALL leave the BTB unchanged.
REQ-027 An update and a lookup on the same index in the same cycle SHALL see pre-update contents for the lookup, with no bypass; the update is visible from the next cycle.
REQ-028 Updates SHALL be accepted regardless of stall, flush or redirect.
REQ-029 Latency SHALL be one cycle from a redirect/flush input to the new o_pc.

Reset
REQ-030 While i_reset = 1, o_pc SHALL equal RESET_VECTOR, all BTB valid bits SHALL be 0, and all counters SHALL be 2'b01, asynchronously and independent of i_clk.
REQ-031 Assertion of i_reset mid-operation SHALL discard any same-cycle update, flush or redirect.
REQ-032 The first edge after reset deassertion SHALL apply normal next-PC selection.

Verification
REQ-033 Reset release, no stall, empty BTB -> o_pc sequence 0x0, 0x4, 0x8, 0xC; o_pred_taken = 0 throughout.
REQ-034 i_stall = 1 for 3 cycles at o_pc = 0x10 -> o_pc holds 0x10; i_redirect_valid = 1, i_redirect_pc = 0x200 during the stall -> o_pc = 0x200 next cycle.
REQ-035 i_flush_valid = 1 (0x80) and i_redirect_valid = 1 (0x200) in the same cycle -> o_pc = 0x80.
REQ-036 Update pc = 0x40, target = 0x100, taken -> when o_pc later reaches 0x40: o_pred_taken = 1, o_pred_target = 0x100, next o_pc = 0x100; two not-taken updates for 0x40 -> counter = 2'b00, o_pred_taken = 0.
REQ-037 Aliasing with BTB_DEPTH = 16: allocate 0x40, then taken update for 0x80 (same index, different tag) -> a lookup at 0x40 misses.
REQ-038 o_pc = 0xFFFF_FFFC with no prediction -> next o_pc = 0x0; async i_reset pulse mid-cycle -> o_pc = RESET_VECTOR immediately and the BTB is cleared.
